// File: rtl/dsp_sys_arr_pkg.sv
// Purpose : shared types and constants for the systolic-array result drain.
// Contents: single_float element type, drain FSM state enum, drain order codes.
// Latency/backpressure: n/a (types only).
package dsp_sys_arr_pkg;

  typedef logic [31:0] single_float;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  localparam int DRAIN_ROW_MAJOR = 0;
  localparam int DRAIN_COL_MAJOR = 1;

endpackage

// File: rtl/sat_cycle_counter.sv
// Purpose : up-counter with synchronous clear and saturation at all-ones.
// Latency : count visible the cycle after the enabling edge; clear wins over enable.
// Ports   : i_clk, i_rst (async, active-high), i_clr, i_en, o_cnt[CNT_W].
module sat_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sys_array_drain.sv
// Purpose : capture an M x K result matrix at array completion, then stream it
//           out one element per handshake (row- or column-major), timing the run
//           and latching array errors.
// Latency : first element valid 1 cycle after the capture edge; 1 element/cycle.
// Backpressure: out_ready low holds out_valid/out_data/out_row/out_col/out_last.
// Ports   : CLK, RST (async active-high); start, arr_done, arr_error, arr_res in;
//           out_valid/out_ready/out_data/out_row/out_col/out_last stream;
//           busy, cycles, err_sticky, done status.
module sys_array_drain
  import dsp_sys_arr_pkg::*;
#(
  parameter  int M     = 2,
  parameter  int K     = 2,
  parameter  int DW    = $bits(single_float),
  parameter  int CNT_W = 32,
  parameter  int ORDER = DRAIN_ROW_MAJOR,
  localparam int RW    = (M > 1) ? $clog2(M) : 1,
  localparam int CW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              arr_done,
  input  logic              arr_error,
  input  logic [M*K*DW-1:0] arr_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  cycles,
  output logic              err_sticky,
  output logic              done
);

  drain_state_t  r_state;
  drain_state_t  w_next;
  logic [DW-1:0] r_buf [M][K];
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_err;
  logic          r_done;

  logic w_start_go;
  logic w_capture;
  logic w_hs;
  logic w_row_end;
  logic w_col_end;
  logic w_last;

  assign w_start_go = (r_state == IDLE) && start;
  assign w_capture  = (r_state == RUN) && arr_done;
  assign w_hs       = (r_state == DRAIN) && out_ready;
  assign w_row_end  = (r_row == RW'(M - 1));
  assign w_col_end  = (r_col == CW'(K - 1));
  // (M-1, K-1) is the final element in either drain order.
  assign w_last     = w_row_end && w_col_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (arr_done) w_next = DRAIN;
      DRAIN:   if (w_hs && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Two wrap counters; ORDER picks which one is inner. The final handshake
  // wraps both back to zero, so idle indices always read 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_capture) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_hs) begin
      if (ORDER == DRAIN_ROW_MAJOR) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        if (w_row_end) begin
          r_row <= '0;
          r_col <= w_col_end ? '0 : r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  // Capture buffer is deliberately not reset: outside DRAIN its contents are
  // never visible, and every run overwrites it completely on capture.
  always_ff @(posedge CLK) begin
    if (w_capture) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < K; j++) begin
          r_buf[i][j] <= arr_res[(i*K+j)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (w_start_go) begin
        r_err <= 1'b0;
      end else if ((r_state == RUN) && arr_error) begin
        r_err <= 1'b1;
      end
    end
  end

  // Counting only in RUN includes the capture edge and freezes afterwards.
  sat_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_cnt (
    .i_clk(CLK),
    .i_rst(RST),
    .i_clr(w_start_go),
    .i_en (r_state == RUN),
    .o_cnt(cycles)
  );

  assign out_valid  = (r_state == DRAIN);
  assign out_data   = out_valid ? r_buf[r_row][r_col] : '0;
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign out_last   = out_valid && w_last;
  assign busy       = (r_state != IDLE);
  assign err_sticky = r_err;
  assign done       = r_done;

endmodule

// File: tb/tb_sys_array_drain.sv
module tb_sys_array_drain;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // Instance 0: 2x2 row-major, 32-bit counter. Instance 1: 2x3 column-major, 4-bit counter.
  logic         start_v [2];
  logic         adone_v [2];
  logic         aerr_v  [2];
  logic         rdy_v   [2];
  logic [191:0] res_v   [2];

  logic        a_valid, a_last, a_busy, a_err, a_done;
  logic [31:0] a_data, a_cycles;
  logic        a_row, a_col;
  logic        b_valid, b_last, b_busy, b_err, b_done;
  logic [31:0] b_data;
  logic [3:0]  b_cycles;
  logic        b_row;
  logic [1:0]  b_col;

  sys_array_drain #(.M(2), .K(2), .DW(32), .CNT_W(32), .ORDER(0)) u_dut_a (
    .CLK(CLK), .RST(RST), .start(start_v[0]), .arr_done(adone_v[0]), .arr_error(aerr_v[0]),
    .arr_res(res_v[0][127:0]), .out_valid(a_valid), .out_ready(rdy_v[0]), .out_data(a_data),
    .out_row(a_row), .out_col(a_col), .out_last(a_last), .busy(a_busy), .cycles(a_cycles),
    .err_sticky(a_err), .done(a_done)
  );

  sys_array_drain #(.M(2), .K(3), .DW(32), .CNT_W(4), .ORDER(1)) u_dut_b (
    .CLK(CLK), .RST(RST), .start(start_v[1]), .arr_done(adone_v[1]), .arr_error(aerr_v[1]),
    .arr_res(res_v[1]), .out_valid(b_valid), .out_ready(rdy_v[1]), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .out_last(b_last), .busy(b_busy), .cycles(b_cycles),
    .err_sticky(b_err), .done(b_done)
  );

  logic        o_valid [2], o_last [2], o_busy [2], o_err [2], o_done [2];
  logic [31:0] o_data [2], o_cycles [2], o_row [2], o_col [2];

  always_comb begin
    o_valid[0] = a_valid;  o_valid[1] = b_valid;
    o_last[0]  = a_last;   o_last[1]  = b_last;
    o_busy[0]  = a_busy;   o_busy[1]  = b_busy;
    o_err[0]   = a_err;    o_err[1]   = b_err;
    o_done[0]  = a_done;   o_done[1]  = b_done;
    o_data[0]  = a_data;   o_data[1]  = b_data;
    o_cycles[0] = a_cycles;
    o_cycles[1] = 32'(b_cycles);
    o_row[0] = 32'(a_row); o_row[1] = 32'(b_row);
    o_col[0] = 32'(a_col); o_col[1] = 32'(b_col);
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] vals [6];

  typedef struct {
    logic [31:0] v;
    int          r;
    int          c;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int s);
    chk("rst_valid", 32'(o_valid[s]), 0);
    chk("rst_data", o_data[s], 0);
    chk("rst_row", o_row[s], 0);
    chk("rst_col", o_col[s], 0);
    chk("rst_last", 32'(o_last[s]), 0);
    chk("rst_busy", 32'(o_busy[s]), 0);
    chk("rst_cycles", o_cycles[s], 0);
    chk("rst_err", 32'(o_err[s]), 0);
    chk("rst_done", 32'(o_done[s]), 0);
  endtask

  // One full run on instance s: start, arr_done n cycles later, drain.
  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // abort_at > 0: assert RST once that many elements have been accepted.
  task automatic run(input int s, input int n, input int err_at, input bit both,
                     input int mode, input int abort_at);
    int          kk;
    exp_t        q[$];
    int          idx;
    int          guard;
    bit          rdy;
    logic [31:0] exp_cyc;
    bit          exp_err;
    kk      = (s == 0) ? 2 : 3;
    exp_cyc = (s == 1 && n > 15) ? 32'd15 : 32'(n);
    exp_err = (err_at >= 1) && (err_at <= n);
    // Reference order: instance 0 row-major, instance 1 column-major.
    if (s == 0) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < kk; c++) q.push_back('{vals[r*kk+c], r, c});
    end else begin
      for (int c = 0; c < kk; c++)
        for (int r = 0; r < 2; r++) q.push_back('{vals[r*kk+c], r, c});
    end

    @(negedge CLK);
    res_v[s] = '0;
    for (int e = 0; e < 2*kk; e++) res_v[s][e*32 +: 32] = vals[e];
    start_v[s] = 1'b1;
    adone_v[s] = both;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        chk("run_busy", 32'(o_busy[s]), 1);
        chk("start_wins", 32'(o_valid[s]), 0);
        chk("err_cleared", 32'(o_err[s]), 0);
        chk("cycles_cleared", o_cycles[s], 0);
      end
      start_v[s] = 1'b0;
      adone_v[s] = (k == n);
      aerr_v[s]  = (k == err_at);
    end
    @(negedge CLK);
    adone_v[s] = 1'b0;
    aerr_v[s]  = 1'b0;
    chk("cycles", o_cycles[s], exp_cyc);
    chk("first_valid", 32'(o_valid[s]), 1);

    idx = 0;
    guard = 0;
    while (idx < q.size() && guard < 100) begin
      if (abort_at > 0 && idx == abort_at) begin
        rdy_v[s] = 1'b0;
        #1 RST = 1'b1;
        #1;
        check_zero(s);
        @(negedge CLK);
        RST = 1'b0;
        chk("no_done_after_rst", 32'(o_done[s]), 0);
        @(negedge CLK);
        chk("no_done_after_rst2", 32'(o_done[s]), 0);
        return;
      end
      chk("drain_valid", 32'(o_valid[s]), 1);
      chk("drain_data", o_data[s], q[idx].v);
      chk("drain_row", o_row[s], q[idx].r);
      chk("drain_col", o_col[s], q[idx].c);
      chk("drain_last", 32'(o_last[s]), 32'(idx == q.size() - 1));
      chk("cycles_frozen", o_cycles[s], exp_cyc);
      chk("drain_done_low", 32'(o_done[s]), 0);
      res_v[s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (guard % 3 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      rdy_v[s] = rdy;
      @(negedge CLK);
      if (rdy) idx++;
      guard++;
    end
    chk("drain_complete", idx, q.size());
    rdy_v[s] = 1'b0;
    chk("done_pulse", 32'(o_done[s]), 1);
    chk("done_busy_low", 32'(o_busy[s]), 0);
    chk("done_valid_low", 32'(o_valid[s]), 0);
    chk("err_sticky", 32'(o_err[s]), 32'(exp_err));
    @(negedge CLK);
    chk("done_one_cycle", 32'(o_done[s]), 0);
  endtask

  task automatic rand_vals();
    for (int e = 0; e < 6; e++) vals[e] = $urandom;
  endtask

  initial begin
    RST = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0; adone_v[s] = 1'b0; aerr_v[s] = 1'b0; rdy_v[s] = 1'b0;
      res_v[s] = '0;
    end
    @(negedge CLK);
    check_zero(0);
    check_zero(1);
    @(negedge CLK);
    RST = 1'b0;

    vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
    vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
    vals[4] = 32'h0;         vals[5] = 32'h0;
    run(0, 7, 0, 1'b0, 0, 0);

    for (int e = 0; e < 6; e++) vals[e] = 32'(e);
    run(1, 5, 0, 1'b0, 0, 0);

    rand_vals();
    run(0, 6, 3, 1'b0, 1, 0);
    rand_vals();
    run(0, $urandom_range(1, 12), 0, 1'b1, 2, 0);
    rand_vals();
    run(1, 20, 0, 1'b0, 2, 0);
    rand_vals();
    run(0, 5, 0, 1'b0, 0, 2);
    rand_vals();
    run(0, 4, 0, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      rand_vals();
      run(i % 2, $urandom_range(1, 25), $urandom_range(0, 8), 1'($urandom_range(0, 1)), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_array_drain.md
# sys_array_drain

Parametrised result collector for the `sys_array` systolic array. It replaces the fixed 2x2 result-port readout with an M×K capture buffer. After a started run completes, it streams every result element out through a valid/ready handshake, in row-major or column-major order. It also measures run latency in cycles and latches array errors, so a bench or host can time and check any array size through one narrow port.

## Interface
Parameters:
- `M`, 2, result rows (≥1)
- `K`, 2, result columns (≥1)
- `DW`, 32, element width (32 = `single_float`)
- `CNT_W`, 32, cycle-counter width
- `ORDER`, 0, drain order: 0 row-major, 1 column-major

Ports:
- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `arr_done`  in  1  array completion strobe; sampled only in RUN
- `arr_error`  in  1  array error flag; sampled in RUN
- `arr_res`  in  M*K*DW  flat results; element (i,j) at `[(i*K+j)*DW +: DW]`
- `out_valid`  out  1  element available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DW  current element
- `out_row`  out  max(1,$clog2(M))  row index of `out_data`
- `out_col`  out  max(1,$clog2(K))  column index of `out_data`
- `out_last`  out  1  current element is the final one
- `busy`  out  1  state ≠ IDLE
- `cycles`  out  CNT_W  run latency, saturating
- `err_sticky`  out  1  error seen during the last run
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 → RUN.
  - On the same edge, `cycles`←0 and `err_sticky`←0.
  - `arr_done` and `arr_error` are ignored.
- RUN:
  - Each edge, `cycles`←`cycles`+1, saturating at all-ones.
  - `arr_error`=1 on any edge sets `err_sticky`.
  - `arr_done`=1 → capture all of `arr_res` into the buffer; index←0; → DRAIN.
  - The increment on the capture edge still applies. After that, `cycles` is frozen.
  - `start` is ignored.
- DRAIN:
  - `out_valid`=1; `out_data`=buf[index].
  - Handshake = `out_valid & out_ready`; each handshake advances the index.
  - ORDER=0: column is inner, row is outer. ORDER=1: row is inner.
  - The handshake on the element with `out_last`=1 → IDLE, and `done`=1 on the next cycle.
  - `start`, `arr_done` and `arr_error` are ignored. The buffer is immune to `arr_res` changes.
- Boundaries:
  - M=K=1: the single element has `out_last`=1 immediately.
  - `out_ready` held low: `out_valid`/`out_data` are held indefinitely, with no loss.
  - `start` and `arr_done` both high in IDLE: only `start` acts.
- RST asserted in any state, including mid-drain:
  - State→IDLE; all outputs 0.
  - The buffer contents are discarded; no `done` pulse.

## Timing
- `start` sampled at edge e0 and `arr_done` sampled at edge e0+n → `cycles`=n.
- `out_valid` rises in the cycle after the capture edge. Capture-to-first-data latency is 1 cycle.
- Throughput is 1 element/cycle while `out_ready`=1. A full drain takes M*K cycles minimum.
- `out_data`, `out_row`, `out_col` and `out_last` are valid whenever `out_valid`=1, and change only after a handshake.
- `done` is registered and lasts exactly 1 cycle. `busy` is low in that same cycle, so a new `start` is accepted there.
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `busy`=0, `cycles`=0, `err_sticky`=0, `done`=0.

## Structure
- `dsp_sys_arr_pkg` holds:
  - `single_float`
  - `drain_state_t` enum (IDLE/RUN/DRAIN)
  - `DRAIN_ROW_MAJOR`/`DRAIN_COL_MAJOR` constants
- One sub-module, `sat_cycle_counter`, parameterised on CNT_W, with clear/enable/saturate.
- The row/column index generator stays inline: two wrap counters, with the inner counter chosen by ORDER.

## Test plan
- M=2, K=2, ORDER=0; `start`; `arr_done` 7 cycles later with results 1.0, 2.0, 3.0, 4.0 → `cycles`=7; drain emits 0x3F800000, 0x40000000, 0x40400000, 0x40800000; `out_last` on the 4th beat; `done` pulse.
- M=2, K=3, ORDER=1, elements 0..5 → order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2), with values 0, 3, 1, 4, 2, 5.
- `out_ready` toggled 1,0,0,1,… → no element dropped or duplicated; data stable while stalled; `arr_res` changed mid-drain has no effect.
- `arr_error` pulse mid-RUN → `err_sticky`=1 after the drain; next `start` clears it to 0.
- CNT_W=4 with `arr_done` after 20 cycles → `cycles`=15, saturated.
- RST asserted after 2 of 4 beats → all outputs 0 asynchronously, no `done`; a following `start`/`arr_done` drains all 4 elements from index 0.
